mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit that writes the HI/LO register pair of the multicycle CPU.
- Takes two operands from the operand muxes (register A/B or memory data) on a start pulse.
- Iterates one bit per cycle. Reports completion, plus a divide-by-zero indication that the control unit uses to raise the Div0 exception.
- Generalises a fixed 32-bit signed-only mult/div to any width, with an optional unsigned mode.

---
 rtl/mult_div_unit_if.sv | 18 +
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake/operand bundle between the control unit (master) and the iterative
// multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (output start, op, a, b, input hi, lo, busy, done, div_zero);
  modport slave  (input start, op, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle signed multiply / restoring divide writing HI/LO.
// Optional unsigned mode (op[0]) is built only when MDU_UNSIGNED_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands latched as magnitudes on start
// CALC  | WIDTH shift-add / restoring-divide iterations
// FIX   | sign correction and HI/LO write (skipped write on divide by zero)
// DONE  | one-cycle done (and div_zero) pulse
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave mdu
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic op_signed;
`ifdef MDU_UNSIGNED_EN
  assign op_signed = ~mdu.op[0];
`else
  logic unused_op0;
  assign op_signed  = 1'b1;
  assign unused_op0 = mdu.op[0];
`endif

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = op_signed & mdu.a[WIDTH-1];
  assign b_neg = op_signed & mdu.b[WIDTH-1];
  assign a_mag = a_neg ? -mdu.a : mdu.a;
  assign b_mag = b_neg ? -mdu.b : mdu.b;

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: {remainder, quotient} shift left; diff's top bit flags a restore.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_neg;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = {1'b0, rem_sh} - {2'b00, mcand_q};
  assign div_neg  = div_diff[WIDTH+1];
  assign rem_new  = div_neg ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], ~div_neg};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          is_div_d  = mdu.op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          mcand_d   = b_mag;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          cnt_d     = '0;
          // Divide by zero skips iteration; FIX leaves HI/LO untouched.
          if (mdu.op[1] && (mdu.b == '0)) begin
            dz_d    = 1'b1;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!dz_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign mdu.hi       = hi_q;
  assign mdu.lo       = lo_q;
  assign mdu.busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign mdu.done     = (state_q == S_DONE);
  assign mdu.div_zero = (state_q == S_DONE) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=32, with hand sequences for
// divide-by-zero, ignored restart and mid-operation reset.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clock;
  logic reset;

  mult_div_unit_if #(.WIDTH(W)) mdu ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .mdu   (mdu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;
  int lat;
  int busyc;
  logic [W-1:0] r_hi, r_lo;
  logic r_dz;
  logic timed_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts edges (lat already holds edges seen since the start edge) until done.
  task automatic wait_done();
    timed_out = 1'b0;
    forever begin
      @(negedge clock);
      if (mdu.done) begin
        r_hi = mdu.hi;
        r_lo = mdu.lo;
        r_dz = mdu.div_zero;
        break;
      end
      if (mdu.busy) busyc++;
      if (lat > 200) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clock);
      lat++;
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    mdu.start = 1'b1;
    mdu.op    = op;
    mdu.a     = a;
    mdu.b     = b;
    @(posedge clock);
    #1 mdu.start = 1'b0;
    lat   = 1;
    busyc = 0;
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clock);
    chk({name, "_done_pulse_width"}, {31'd0, mdu.done}, 32'd0);
    chk({name, "_idle_busy"}, {31'd0, mdu.busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[3]  = '{2'b00, 32'd7,        32'd6,        32'h00000000, 32'd42};
    vecs[4]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[8]  = '{2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30};
`ifdef MDU_UNSIGNED_EN
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF};
`else
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'h00000000};
`endif

    reset     = 1'b0;
    mdu.start = 1'b0;
    mdu.op    = 2'b00;
    mdu.a     = '0;
    mdu.b     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_hi", mdu.hi, 32'd0);
    chk("reset_lo", mdu.lo, 32'd0);
    chk("reset_busy", {31'd0, mdu.busy}, 32'd0);
    chk("reset_done", {31'd0, mdu.done}, 32'd0);
    chk("reset_dz", {31'd0, mdu.div_zero}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done();
      chk($sformatf("v%0d_timeout", i), {31'd0, timed_out}, 32'd0);
      chk($sformatf("v%0d_latency", i), lat, 32'd34);
      chk($sformatf("v%0d_busy_cycles", i), busyc, 32'd33);
      chk($sformatf("v%0d_hi", i), r_hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), r_lo, vecs[i].lo);
      chk($sformatf("v%0d_dz", i), {31'd0, r_dz}, 32'd0);
      check_idle_after($sformatf("v%0d", i));
    end

    // Divide by zero after preloading HI/LO with 6*7.
    launch(2'b00, 32'd6, 32'd7);
    wait_done();
    chk("dz_pre_lo", r_lo, 32'd42);
    launch(2'b10, 32'd9, 32'd0);
    wait_done();
    chk("dz_timeout", {31'd0, timed_out}, 32'd0);
    chk("dz_latency", lat, 32'd2);
    chk("dz_flag", {31'd0, r_dz}, 32'd1);
    chk("dz_hi_kept", r_hi, 32'd0);
    chk("dz_lo_kept", r_lo, 32'd42);
    check_idle_after("dz");
    @(negedge clock);
    chk("dz_hi_after", mdu.hi, 32'd0);
    chk("dz_lo_after", mdu.lo, 32'd42);

    // Second start at edge k+5 with other operands must be ignored.
    launch(2'b00, 32'd3, 32'd4);
    repeat (4) begin
      @(posedge clock);
      lat++;
    end
    @(negedge clock);
    mdu.start = 1'b1;
    mdu.a     = 32'd100;
    mdu.b     = 32'd100;
    @(posedge clock);
    lat++;
    #1 mdu.start = 1'b0;
    wait_done();
    chk("ign_latency", lat, 32'd34);
    chk("ign_hi", r_hi, 32'd0);
    chk("ign_lo", r_lo, 32'd12);
    check_idle_after("ign");

    // Reset asserted at edge k+10 of a divide.
    launch(2'b10, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_busy", {31'd0, mdu.busy}, 32'd0);
    chk("rst_hi", mdu.hi, 32'd0);
    chk("rst_lo", mdu.lo, 32'd0);
    reset = 1'b1;
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (60) begin
        @(negedge clock);
        if (mdu.done || mdu.busy) seen_done = 1'b1;
      end
      chk("rst_no_done", {31'd0, seen_done}, 32'd0);
    end
    launch(2'b10, 32'd1000, 32'd3);
    wait_done();
    chk("rst_new_latency", lat, 32'd34);
    chk("rst_new_hi", r_hi, 32'd1);
    chk("rst_new_lo", r_lo, 32'd333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
